// File: rtl/l2_pkg.sv
// Shared types and width helpers for the L2 controller with multi-entry eviction write buffer.
package l2_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAIN = 3'd1,
        S_EVICT = 3'd2,
        S_FILL  = 3'd3,
        S_RESP  = 3'd4
    } l2_ctrl_state_t;

    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/l2_cache_ctrl_mwb_ewb_ptrs.sv
// Eviction write buffer FIFO bookkeeping: head/tail pointers, occupancy and full/empty flags.
module l2_ewb_ptrs
    import l2_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = ptr_bits(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    output logic [PTR_W-1:0] o_wr_ptr,
    output logic [PTR_W-1:0] o_rd_ptr,
    output logic [PTR_W:0]   o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (i_push && !i_pop)      r_count <= r_count + (PTR_W+1)'(1);
            else if (i_pop && !i_push) r_count <= r_count - (PTR_W+1)'(1);
        end
    end

    assign o_wr_ptr = r_wr_ptr;
    assign o_rd_ptr = r_rd_ptr;
    assign o_count  = r_count;
    assign o_full   = (r_count == DEPTH_C);
    assign o_empty  = (r_count == '0);

    a_count_bound: assert property (@(posedge clk) disable iff (rst) r_count <= DEPTH_C);
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(i_push && o_full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(i_pop && o_empty));
    a_no_push_pop: assert property (@(posedge clk) disable iff (rst) !(i_push && i_pop));

endmodule

// File: rtl/l2_cache_ctrl_mwb.sv
// L2 controller FSM: N-way tag/data control, EWB FIFO push/drain/merge, idle background drain, perf counters.
module l2_cache_ctrl_mwb
    import l2_pkg::*;
#(
    parameter  int WAYS       = 8,
    parameter  int EWB_DEPTH  = 4,
    parameter  int IDLE_DRAIN = 2,
    parameter  int CNT_W      = 32,
    localparam int WAY_W      = way_bits(WAYS),
    localparam int PTR_W      = ptr_bits(EWB_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_mem_read,
    input  logic             i_mem_write,
    output logic             o_mem_resp,
    input  logic             i_cache_hit,
    input  logic [WAY_W-1:0] i_hit_idx,
    input  logic [WAY_W-1:0] i_plru_idx,
    input  logic             i_dirty_o,
    input  logic             i_ewb_hit,
    input  logic [PTR_W-1:0] i_ewb_hit_ptr,
    output logic [WAY_W-1:0] o_way_sel,
    output logic             o_tag_sel,
    output logic             o_source_sel,
    output logic             o_load_cache,
    output logic             o_load_dirty,
    output logic             o_load_lru,
    output logic             o_ewb_push,
    output logic             o_ewb_merge,
    output logic [PTR_W-1:0] o_ewb_wr_ptr,
    output logic [PTR_W-1:0] o_ewb_rd_ptr,
    output logic [PTR_W:0]   o_ewb_count,
    output logic             o_addr_sel,
    output logic             o_read_from_mem,
    output logic             o_write_to_mem,
    input  logic             i_resp_from_mem,
    output logic [CNT_W-1:0] o_num_hits,
    output logic [CNT_W-1:0] o_num_misses,
    output logic [CNT_W-1:0] o_num_wbs,
    output l2_ctrl_state_t   o_state
);

    localparam int TMR_W = (IDLE_DRAIN > 1) ? $clog2(IDLE_DRAIN + 1) : 1;
    localparam logic [TMR_W-1:0] IDLE_LAST = TMR_W'(IDLE_DRAIN - 1);

    l2_ctrl_state_t   r_state;
    l2_ctrl_state_t   w_next;
    logic [TMR_W-1:0] r_idle_tmr;
    logic             r_miss_pending;
    logic [CNT_W-1:0] r_num_hits;
    logic [CNT_W-1:0] r_num_misses;
    logic [CNT_W-1:0] r_num_wbs;

    logic             w_req;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_hit_inc;
    logic             w_miss_inc;
    logic             w_wb_inc;
    logic             w_pend_set;
    logic             w_ewb_hit_ok;
    logic [PTR_W-1:0] w_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr;
    logic [PTR_W:0]   w_count;
    logic [PTR_W-1:0] w_hit_ofs;

    l2_ewb_ptrs #(.DEPTH(EWB_DEPTH)) u_ewb_ptrs (
        .clk      (clk),
        .rst      (rst),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .o_wr_ptr (w_wr_ptr),
        .o_rd_ptr (w_rd_ptr),
        .o_count  (w_count),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    assign w_req = i_mem_read | i_mem_write;

    // A match against an entry outside the occupied head..tail window is stale and ignored.
    assign w_hit_ofs    = i_ewb_hit_ptr - w_rd_ptr;
    assign w_ewb_hit_ok = i_ewb_hit && ({1'b0, w_hit_ofs} < w_count);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        o_mem_resp      = 1'b0;
        o_way_sel       = i_hit_idx;
        o_tag_sel       = 1'b1;
        o_source_sel    = 1'b0;
        o_load_cache    = 1'b0;
        o_load_dirty    = 1'b0;
        o_load_lru      = 1'b0;
        o_ewb_merge     = 1'b0;
        o_addr_sel      = 1'b0;
        o_read_from_mem = 1'b0;
        o_write_to_mem  = 1'b0;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        w_hit_inc       = 1'b0;
        w_miss_inc      = 1'b0;
        w_wb_inc        = 1'b0;
        w_pend_set      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (i_cache_hit || w_ewb_hit_ok) begin
                        w_next    = S_RESP;
                        w_hit_inc = 1'b1;
                    end else begin
                        w_miss_inc = 1'b1;
                        if (i_dirty_o && w_full) begin
                            w_next     = S_DRAIN;
                            w_pend_set = 1'b1;
                        end else if (i_dirty_o) begin
                            w_next = S_EVICT;
                        end else begin
                            w_next = S_FILL;
                        end
                    end
                end else if (!w_empty && r_idle_tmr == IDLE_LAST) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Drains run to completion; a new request is only looked at back in S_IDLE.
                o_write_to_mem = 1'b1;
                o_addr_sel     = 1'b1;
                if (i_resp_from_mem) begin
                    w_pop    = 1'b1;
                    w_wb_inc = 1'b1;
                    if (r_miss_pending) w_next = i_dirty_o ? S_EVICT : S_FILL;
                    else                w_next = S_IDLE;
                end
            end
            S_EVICT: begin
                o_way_sel = i_plru_idx;
                o_tag_sel = 1'b0;
                w_push    = 1'b1;
                w_next    = S_FILL;
            end
            S_FILL: begin
                o_read_from_mem = 1'b1;
                o_way_sel       = i_plru_idx;
                if (i_resp_from_mem) begin
                    o_load_cache = 1'b1;
                    o_source_sel = 1'b1;
                    o_load_dirty = 1'b1;
                    w_next       = S_RESP;
                end
            end
            S_RESP: begin
                o_mem_resp = 1'b1;
                if (w_ewb_hit_ok) begin
                    o_ewb_merge = i_mem_write;
                end else begin
                    o_load_cache = i_mem_write;
                    o_load_dirty = i_mem_write;
                    o_load_lru   = 1'b1;
                end
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_tmr <= '0;
        end else if (r_state == S_IDLE && !w_req && w_next == S_IDLE) begin
            if (r_idle_tmr != IDLE_LAST) r_idle_tmr <= r_idle_tmr + TMR_W'(1);
        end else begin
            r_idle_tmr <= '0;
        end
    end

    // Remembers that a drain was forced by a full EWB so the miss resumes afterwards.
    always_ff @(posedge clk) begin
        if (rst)             r_miss_pending <= 1'b0;
        else if (w_pend_set) r_miss_pending <= 1'b1;
        else if (w_pop)      r_miss_pending <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_hits   <= '0;
            r_num_misses <= '0;
            r_num_wbs    <= '0;
        end else begin
            if (w_hit_inc && r_num_hits != '1)    r_num_hits   <= r_num_hits + CNT_W'(1);
            if (w_miss_inc && r_num_misses != '1) r_num_misses <= r_num_misses + CNT_W'(1);
            if (w_wb_inc && r_num_wbs != '1)      r_num_wbs    <= r_num_wbs + CNT_W'(1);
        end
    end

    assign o_ewb_push   = w_push;
    assign o_ewb_wr_ptr = w_wr_ptr;
    assign o_ewb_rd_ptr = w_rd_ptr;
    assign o_ewb_count  = w_count;
    assign o_num_hits   = r_num_hits;
    assign o_num_misses = r_num_misses;
    assign o_num_wbs    = r_num_wbs;
    assign o_state      = r_state;

endmodule

// File: tb/tb_l2_cache_ctrl_mwb.sv
// Directed, table-driven bench for l2_cache_ctrl_mwb (WAYS=8, EWB_DEPTH=4, IDLE_DRAIN=2).
module tb_l2_cache_ctrl_mwb;
    import l2_pkg::*;

    logic clk, rst;
    logic i_mem_read, i_mem_write, i_cache_hit, i_dirty_o, i_ewb_hit, i_resp_from_mem;
    logic [2:0] i_hit_idx, i_plru_idx;
    logic [1:0] i_ewb_hit_ptr;
    logic o_mem_resp, o_tag_sel, o_source_sel, o_load_cache, o_load_dirty, o_load_lru;
    logic o_ewb_push, o_ewb_merge, o_addr_sel, o_read_from_mem, o_write_to_mem;
    logic [2:0] o_way_sel;
    logic [1:0] o_ewb_wr_ptr, o_ewb_rd_ptr;
    logic [2:0] o_ewb_count;
    logic [31:0] o_num_hits, o_num_misses, o_num_wbs;
    l2_ctrl_state_t o_state;

    int n_vec = 0;
    int n_bad = 0;

    l2_cache_ctrl_mwb dut (
        .clk(clk), .rst(rst),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .o_mem_resp(o_mem_resp),
        .i_cache_hit(i_cache_hit), .i_hit_idx(i_hit_idx), .i_plru_idx(i_plru_idx),
        .i_dirty_o(i_dirty_o), .i_ewb_hit(i_ewb_hit), .i_ewb_hit_ptr(i_ewb_hit_ptr),
        .o_way_sel(o_way_sel), .o_tag_sel(o_tag_sel), .o_source_sel(o_source_sel),
        .o_load_cache(o_load_cache), .o_load_dirty(o_load_dirty), .o_load_lru(o_load_lru),
        .o_ewb_push(o_ewb_push), .o_ewb_merge(o_ewb_merge),
        .o_ewb_wr_ptr(o_ewb_wr_ptr), .o_ewb_rd_ptr(o_ewb_rd_ptr), .o_ewb_count(o_ewb_count),
        .o_addr_sel(o_addr_sel), .o_read_from_mem(o_read_from_mem), .o_write_to_mem(o_write_to_mem),
        .i_resp_from_mem(i_resp_from_mem),
        .o_num_hits(o_num_hits), .o_num_misses(o_num_misses), .o_num_wbs(o_num_wbs),
        .o_state(o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // flags = {mem_resp, load_cache, load_dirty, load_lru, ewb_push, ewb_merge, read_from_mem, write_to_mem}
    typedef struct {
        logic rd, wr, hit;
        logic [2:0] hidx, pidx;
        logic dirty, eh;
        logic [1:0] ehp;
        logic mresp;
        l2_ctrl_state_t st;
        logic [7:0] flags;
        logic [2:0] way, cnt;
        logic [1:0] wp, rp;
        int h, m, w;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rd, input logic wr, input logic hit, input int hidx, input int pidx,
                       input logic dirty, input logic eh, input int ehp, input logic mresp,
                       input l2_ctrl_state_t st, input logic [7:0] flags,
                       input int way, input int cnt, input int wp, input int rp,
                       input int h, input int m, input int w);
        vec_t v;
        v.rd = rd; v.wr = wr; v.hit = hit; v.hidx = 3'(hidx); v.pidx = 3'(pidx);
        v.dirty = dirty; v.eh = eh; v.ehp = 2'(ehp); v.mresp = mresp;
        v.st = st; v.flags = flags; v.way = 3'(way); v.cnt = 3'(cnt);
        v.wp = 2'(wp); v.rp = 2'(rp); v.h = h; v.m = m; v.w = w;
        vecs.push_back(v);
    endtask

    task automatic idle_in();
        i_mem_read = 0; i_mem_write = 0; i_cache_hit = 0; i_hit_idx = 0; i_plru_idx = 0;
        i_dirty_o = 0; i_ewb_hit = 0; i_ewb_hit_ptr = 0; i_resp_from_mem = 0;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    initial begin
        logic [20:0] act, exp;
        logic [2:0] aux_act, aux_exp;
        logic ctr_ok;

        // Reset and plain read hit on way 5.
        add(0,0,0,0,0,0,0,0,0, S_IDLE, 8'b0000_0000, 0,0,0,0, 0,0,0);
        add(1,0,1,5,0,0,0,0,0, S_IDLE, 8'b0000_0000, 5,0,0,0, 0,0,0);
        add(1,0,1,5,0,0,0,0,0, S_RESP, 8'b1001_0000, 5,0,0,0, 1,0,0);
        add(0,0,0,0,0,0,0,0,0, S_IDLE, 8'b0000_0000, 0,0,0,0, 1,0,0);
        // Read miss, clean victim, memory latency 3.
        add(1,0,0,3,3,0,0,0,0, S_IDLE, 8'b0000_0000, 3,0,0,0, 1,0,0);
        add(1,0,0,3,3,0,0,0,0, S_FILL, 8'b0000_0010, 3,0,0,0, 1,1,0);
        add(1,0,0,3,3,0,0,0,0, S_FILL, 8'b0000_0010, 3,0,0,0, 1,1,0);
        add(1,0,0,3,3,0,0,0,1, S_FILL, 8'b0110_0010, 3,0,0,0, 1,1,0);
        add(1,0,0,3,3,0,0,0,0, S_RESP, 8'b1001_0000, 3,0,0,0, 1,1,0);
        add(0,0,0,0,0,0,0,0,0, S_IDLE, 8'b0000_0000, 0,0,0,0, 1,1,0);
        // Four back-to-back dirty misses fill the EWB.
        for (int i = 0; i < 4; i++) begin
            add(1,0,0,i,i,1,0,0,0, S_IDLE,  8'b0000_0000, i,i,i,0,         1,1+i,0);
            add(1,0,0,i,i,1,0,0,0, S_EVICT, 8'b0000_1000, i,i,i,0,         1,2+i,0);
            add(1,0,0,i,i,1,0,0,1, S_FILL,  8'b0110_0010, i,i+1,(i+1)%4,0, 1,2+i,0);
            add(1,0,0,i,i,1,0,0,0, S_RESP,  8'b1001_0000, i,i+1,(i+1)%4,0, 1,2+i,0);
        end
        // Fifth dirty miss with EWB full: drain first, then evict and fill.
        add(1,0,0,5,5,1,0,0,0, S_IDLE,  8'b0000_0000, 5,4,0,0, 1,5,0);
        add(1,0,0,5,5,1,0,0,0, S_DRAIN, 8'b0000_0001, 5,4,0,0, 1,6,0);
        add(1,0,0,5,5,1,0,0,1, S_DRAIN, 8'b0000_0001, 5,4,0,0, 1,6,0);
        add(1,0,0,5,5,1,0,0,0, S_EVICT, 8'b0000_1000, 5,3,0,1, 1,6,1);
        add(1,0,0,5,5,1,0,0,1, S_FILL,  8'b0110_0010, 5,4,1,1, 1,6,1);
        add(1,0,0,5,5,1,0,0,0, S_RESP,  8'b1001_0000, 5,4,1,1, 1,6,1);
        // Write hitting EWB entry 2: merge only.
        add(0,1,0,0,0,0,1,2,0, S_IDLE,  8'b0000_0000, 0,4,1,1, 1,6,1);
        add(0,1,0,0,0,0,1,2,0, S_RESP,  8'b1000_0100, 0,4,1,1, 2,6,1);
        // Two idle cycles start a background drain; a request raised mid-drain waits.
        add(0,0,0,0,0,0,0,0,0, S_IDLE,  8'b0000_0000, 0,4,1,1, 2,6,1);
        add(0,0,0,0,0,0,0,0,0, S_IDLE,  8'b0000_0000, 0,4,1,1, 2,6,1);
        add(0,0,0,0,0,0,0,0,0, S_DRAIN, 8'b0000_0001, 0,4,1,1, 2,6,1);
        add(1,0,1,6,0,0,0,0,0, S_DRAIN, 8'b0000_0001, 6,4,1,1, 2,6,1);
        add(1,0,1,6,0,0,0,0,1, S_DRAIN, 8'b0000_0001, 6,4,1,1, 2,6,1);
        add(1,0,1,6,0,0,0,0,0, S_IDLE,  8'b0000_0000, 6,3,1,2, 2,6,2);
        add(1,0,1,6,0,0,0,0,0, S_RESP,  8'b1001_0000, 6,3,1,2, 3,6,2);
        // One idle cycle is not enough to drain.
        add(0,0,0,0,0,0,0,0,0, S_IDLE,  8'b0000_0000, 0,3,1,2, 3,6,2);
        add(1,0,1,1,0,0,0,0,0, S_IDLE,  8'b0000_0000, 1,3,1,2, 3,6,2);
        add(1,0,1,1,0,0,0,0,0, S_RESP,  8'b1001_0000, 1,3,1,2, 4,6,2);
        add(0,0,0,0,0,0,0,0,0, S_IDLE,  8'b0000_0000, 0,3,1,2, 4,6,2);
        add(0,0,0,0,0,0,0,0,0, S_IDLE,  8'b0000_0000, 0,3,1,2, 4,6,2);
        add(0,0,0,0,0,0,0,0,1, S_DRAIN, 8'b0000_0001, 0,3,1,2, 4,6,2);
        add(0,0,0,0,0,0,0,0,0, S_IDLE,  8'b0000_0000, 0,2,1,3, 4,6,3);
        // Write hit in the arrays.
        add(0,1,1,2,0,0,0,0,0, S_IDLE,  8'b0000_0000, 2,2,1,3, 4,6,3);
        add(0,1,1,2,0,0,0,0,0, S_RESP,  8'b1111_0000, 2,2,1,3, 5,6,3);
        add(0,0,0,0,0,0,0,0,0, S_IDLE,  8'b0000_0000, 0,2,1,3, 5,6,3);

        idle_in();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            i_mem_read = vecs[i].rd; i_mem_write = vecs[i].wr; i_cache_hit = vecs[i].hit;
            i_hit_idx = vecs[i].hidx; i_plru_idx = vecs[i].pidx; i_dirty_o = vecs[i].dirty;
            i_ewb_hit = vecs[i].eh; i_ewb_hit_ptr = vecs[i].ehp; i_resp_from_mem = vecs[i].mresp;
            #2;
            act = {o_state, o_mem_resp, o_load_cache, o_load_dirty, o_load_lru, o_ewb_push,
                   o_ewb_merge, o_read_from_mem, o_write_to_mem, o_way_sel, o_ewb_count,
                   o_ewb_wr_ptr, o_ewb_rd_ptr};
            exp = {vecs[i].st, vecs[i].flags, vecs[i].way, vecs[i].cnt, vecs[i].wp, vecs[i].rp};
            // tag_sel drops only while pushing; source_sel marks the fill load; addr_sel follows the memory write.
            aux_act = {o_tag_sel, o_source_sel, o_addr_sel};
            aux_exp = {~vecs[i].flags[3], vecs[i].flags[6] & vecs[i].flags[1], vecs[i].flags[0]};
            ctr_ok = (o_num_hits == 32'(vecs[i].h)) && (o_num_misses == 32'(vecs[i].m))
                     && (o_num_wbs == 32'(vecs[i].w));
            n_vec++;
            if (act !== exp || aux_act !== aux_exp || !ctr_ok) begin
                n_bad++;
                $display("FAIL vec%0d: got %h/%b ctr %0d/%0d/%0d, want %h/%b ctr %0d/%0d/%0d",
                         i, act, aux_act, o_num_hits, o_num_misses, o_num_wbs,
                         exp, aux_exp, vecs[i].h, vecs[i].m, vecs[i].w);
            end
            @(negedge clk);
        end

        // Reset asserted while a fill is in flight.
        idle_in();
        i_mem_read = 1'b1; i_plru_idx = 3'd4;
        #2 chk("rst_pre_idle", 128'(o_state), 128'(S_IDLE));
        @(negedge clk);
        #2 chk("rst_in_fill", 128'({o_state, o_read_from_mem}), 128'({S_FILL, 1'b1}));
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("rst_state", 128'(o_state), 128'(S_IDLE));
        chk("rst_rfm", 128'(o_read_from_mem), 128'(0));
        chk("rst_count", 128'(o_ewb_count), 128'(0));
        chk("rst_ptrs", 128'({o_ewb_wr_ptr, o_ewb_rd_ptr}), 128'(0));
        chk("rst_ctrs", {32'd0, o_num_hits, o_num_misses, o_num_wbs}, 128'(0));
        rst = 1'b0;
        idle_in();
        @(negedge clk);
        #2 chk("post_rst_idle", 128'({o_state, o_mem_resp, o_write_to_mem}), 128'({S_IDLE, 2'b00}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
